ram_port_arbiter: RTL and testbench

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

---
 rtl/arb_pkg.sv | 20 ++
 rtl/arb_rr_pick.sv | 28 ++
 rtl/ram_port_arbiter.sv | 139 +++++++++++++
 tb/tb_ram_port_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and constants for the two-port RAM arbiter: FSM state
// encoding, port identifiers and default bus widths.
package arb_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    DONE
  } arb_state_t;

  typedef logic port_id_t;

  localparam port_id_t PORT_CPU = 1'b0;
  localparam port_id_t PORT_IO  = 1'b1;

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational winner selection between the cpu and io requesters.
// Round-robin on ties by default; ARB_FIXED_PRIO_EN makes cpu win every tie.
module arb_rr_pick
  import arb_pkg::*;
(
  input  logic     cpu_req,
  input  logic     io_req,
  input  port_id_t last_grant,
  output port_id_t grant,
  output logic     valid
);

  // NOTE: every output is given a value before any branch so no latch is inferred.
  always_comb begin
    valid = cpu_req | io_req;
    grant = PORT_CPU;
    if (io_req && !cpu_req) begin
      grant = PORT_IO;
    end else if (cpu_req && io_req) begin
`ifdef ARB_FIXED_PRIO_EN
      grant = PORT_CPU;
`else
      grant = (last_grant == PORT_CPU) ? PORT_IO : PORT_CPU;
`endif
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port RAM between a processor core and an image loader.
// Tie-break policy selectable with ARB_FIXED_PRIO_EN (see arb_rr_pick).
module ram_port_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,

  input  logic              io_req,
  input  logic              io_we,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic [DATA_W-1:0] io_wdata,
  output logic              io_ack,
  output logic [DATA_W-1:0] io_rdata,

  output logic              mem_RE_RAM,
  output logic              mem_WE_RAM,
  output logic [ADDR_W-1:0] Data_Dir_RAM,
  output logic [DATA_W-1:0] Data_RAM,
  input  logic [DATA_W-1:0] Data_in_RAM
);

  localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

  arb_state_t state;
  arb_state_t next_state;

  port_id_t          pick;
  logic              pick_valid;
  port_id_t          grant;
  port_id_t          last_grant;
  logic              lat_we;
  logic [1:0]        lat_cnt;

  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  arb_rr_pick u_pick (
    .cpu_req    (cpu_req),
    .io_req     (io_req),
    .last_grant (last_grant),
    .grant      (pick),
    .valid      (pick_valid)
  );

  assign sel_we    = (pick == PORT_CPU) ? cpu_we    : io_we;
  assign sel_addr  = (pick == PORT_CPU) ? cpu_addr  : io_addr;
  assign sel_wdata = (pick == PORT_CPU) ? cpu_wdata : io_wdata;

  // NOTE: registers update with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (pick_valid) next_state = ACCESS;
      ACCESS:  next_state = lat_we ? DONE : WAIT;
      WAIT:    if (lat_cnt == LAT_LAST) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Strobes and acks default low each cycle, so each is a one-cycle pulse
  // raised only on the edge that enters ACCESS or DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_RE_RAM   <= 1'b0;
      mem_WE_RAM   <= 1'b0;
      Data_Dir_RAM <= '0;
      Data_RAM     <= '0;
      cpu_ack      <= 1'b0;
      io_ack       <= 1'b0;
      cpu_rdata    <= '0;
      io_rdata     <= '0;
      grant        <= PORT_CPU;
      last_grant   <= PORT_IO;
      lat_we       <= 1'b0;
      lat_cnt      <= '0;
    end else begin
      mem_RE_RAM <= 1'b0;
      mem_WE_RAM <= 1'b0;
      cpu_ack    <= 1'b0;
      io_ack     <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            grant        <= pick;
            lat_we       <= sel_we;
            Data_Dir_RAM <= sel_addr;
            Data_RAM     <= sel_wdata;
            mem_WE_RAM   <= sel_we;
            mem_RE_RAM   <= !sel_we;
          end
        end
        ACCESS: begin
          lat_cnt <= '0;
          if (lat_we) begin
            cpu_ack <= (grant == PORT_CPU);
            io_ack  <= (grant == PORT_IO);
          end
        end
        WAIT: begin
          if (lat_cnt == LAT_LAST) begin
            if (grant == PORT_CPU) cpu_rdata <= Data_in_RAM;
            else                   io_rdata  <= Data_in_RAM;
            cpu_ack <= (grant == PORT_CPU);
            io_ack  <= (grant == PORT_IO);
          end else begin
            lat_cnt <= lat_cnt + 2'd1;
          end
        end
        DONE: begin
          last_grant <= grant;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench: two arbiter instances (RD_LAT 1 and 3), each with a
// latency-accurate RAM model, checked against a transaction-level reference.
module tb_ram_port_arbiter;
  import arb_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset     [2];
  logic              cpu_req   [2];
  logic              cpu_we    [2];
  logic [ADDR_W-1:0] cpu_addr  [2];
  logic [DATA_W-1:0] cpu_wdata [2];
  logic              io_req    [2];
  logic              io_we     [2];
  logic [ADDR_W-1:0] io_addr   [2];
  logic [DATA_W-1:0] io_wdata  [2];

  wire               cpu_ack   [2];
  wire               io_ack    [2];
  wire  [DATA_W-1:0] cpu_rdata [2];
  wire  [DATA_W-1:0] io_rdata  [2];
  wire               mem_re    [2];
  wire               mem_we    [2];
  wire  [ADDR_W-1:0] dir       [2];
  wire  [DATA_W-1:0] dout      [2];

  int total = 0;
  int bad   = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : 3;
    logic [DATA_W-1:0] din = '0;
    logic [3:0]        pv = '0;
    logic [7:0]        pa [4];
    logic [DATA_W-1:0] ram [256];
    logic [255:0]      wr = '0;

    ram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(L)) dut (
      .clk          (clk),
      .reset        (reset[g]),
      .cpu_req      (cpu_req[g]),
      .cpu_we       (cpu_we[g]),
      .cpu_addr     (cpu_addr[g]),
      .cpu_wdata    (cpu_wdata[g]),
      .cpu_ack      (cpu_ack[g]),
      .cpu_rdata    (cpu_rdata[g]),
      .io_req       (io_req[g]),
      .io_we        (io_we[g]),
      .io_addr      (io_addr[g]),
      .io_wdata     (io_wdata[g]),
      .io_ack       (io_ack[g]),
      .io_rdata     (io_rdata[g]),
      .mem_RE_RAM   (mem_re[g]),
      .mem_WE_RAM   (mem_we[g]),
      .Data_Dir_RAM (dir[g]),
      .Data_RAM     (dout[g]),
      .Data_in_RAM  (din)
    );

    // RAM: read data is valid only in the cycle L cycles after the RE cycle;
    // every other cycle it carries junk. Unwritten cells read as addr^0x1C.
    always @(negedge clk) begin
      pv    <= {pv[2:0], mem_re[g]};
      pa[0] <= dir[g][7:0];
      pa[1] <= pa[0];
      pa[2] <= pa[1];
      pa[3] <= pa[2];
      if (mem_we[g]) begin
        ram[dir[g][7:0]] <= dout[g];
        wr[dir[g][7:0]]  <= 1'b1;
      end
      if (pv[L-1]) din <= wr[pa[L-1]] ? ram[pa[L-1]] : (pa[L-1] ^ 8'h1C);
      else         din <= 8'($urandom);
    end
  end

  // Reference state
  port_id_t          last_m  [2];
  logic [DATA_W-1:0] exp_rd  [2][2];
  logic [DATA_W-1:0] ref_mem [2][256];
  logic              ref_wr  [2][256];

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic port_id_t model_pick(input logic c, input logic i, input port_id_t last);
    if (c && !i) return PORT_CPU;
    if (i && !c) return PORT_IO;
`ifdef ARB_FIXED_PRIO_EN
    return PORT_CPU;
`else
    return (last == PORT_IO) ? PORT_CPU : PORT_IO;
`endif
  endfunction

  function automatic logic [7:0] ref_read(input int d, input logic [7:0] a);
    return ref_wr[d][a] ? ref_mem[d][a] : (a ^ 8'h1C);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs_zero(input int d, input string tag);
    check({tag, "_cpu_ack"}, cpu_ack[d], 0);
    check({tag, "_io_ack"}, io_ack[d], 0);
    check({tag, "_re"}, mem_re[d], 0);
    check({tag, "_we"}, mem_we[d], 0);
    check({tag, "_dir"}, dir[d], 0);
    check({tag, "_dout"}, dout[d], 0);
    check({tag, "_cpu_rdata"}, cpu_rdata[d], 0);
    check({tag, "_io_rdata"}, io_rdata[d], 0);
  endtask

  // Runs one transaction starting in an IDLE cycle; returns in the IDLE
  // cycle that follows the ack.
  task automatic do_txn(input int d, input logic c_on, input logic i_on,
                        input logic c_we, input logic i_we,
                        input logic [31:0] c_a, input logic [31:0] i_a,
                        input logic [7:0] c_wd, input logic [7:0] i_wd,
                        input logic early);
    port_id_t    w;
    logic        w_we;
    logic [31:0] w_a;
    logic [7:0]  w_wd;
    int          k;
    w    = model_pick(c_on, i_on, last_m[d]);
    w_we = (w == PORT_CPU) ? c_we : i_we;
    w_a  = (w == PORT_CPU) ? c_a  : i_a;
    w_wd = (w == PORT_CPU) ? c_wd : i_wd;
    k    = w_we ? 2 : 2 + lat_of(d);

    cpu_req[d] = c_on; cpu_we[d] = c_we; cpu_addr[d] = c_a; cpu_wdata[d] = c_wd;
    io_req[d]  = i_on; io_we[d]  = i_we; io_addr[d]  = i_a; io_wdata[d]  = i_wd;

    @(posedge clk); #1;
    check("access_we", mem_we[d], w_we);
    check("access_re", mem_re[d], !w_we);
    check("access_dir", dir[d], w_a);
    if (w_we) check("access_wdata", dout[d], w_wd);
    check("access_cpu_ack", cpu_ack[d], 0);
    check("access_io_ack", io_ack[d], 0);
    if (early) begin
      cpu_req[d] = 1'b0;
      io_req[d]  = 1'b0;
    end

    for (int c = 2; c <= k; c++) begin
      @(posedge clk); #1;
      check("post_we", mem_we[d], 0);
      check("post_re", mem_re[d], 0);
      check("dir_hold", dir[d], w_a);
      check("cpu_ack", cpu_ack[d], (c == k) && (w == PORT_CPU));
      check("io_ack", io_ack[d], (c == k) && (w == PORT_IO));
    end
    cpu_req[d] = 1'b0;
    io_req[d]  = 1'b0;

    if (w_we) begin
      ref_mem[d][w_a[7:0]] = w_wd;
      ref_wr[d][w_a[7:0]]  = 1'b1;
    end else begin
      exp_rd[d][w] = ref_read(d, w_a[7:0]);
    end
    last_m[d] = w;
    check("ack_cpu_rdata", cpu_rdata[d], exp_rd[d][PORT_CPU]);
    check("ack_io_rdata", io_rdata[d], exp_rd[d][PORT_IO]);

    @(posedge clk); #1;
    check("after_cpu_ack", cpu_ack[d], 0);
    check("after_io_ack", io_ack[d], 0);
    check("held_cpu_rdata", cpu_rdata[d], exp_rd[d][PORT_CPU]);
    check("held_io_rdata", io_rdata[d], exp_rd[d][PORT_IO]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    port_id_t w;
    int       n;

    for (int d = 0; d < 2; d++) begin
      reset[d] = 1'b1;
      cpu_req[d] = 1'b0; cpu_we[d] = 1'b0; cpu_addr[d] = '0; cpu_wdata[d] = '0;
      io_req[d]  = 1'b0; io_we[d]  = 1'b0; io_addr[d]  = '0; io_wdata[d]  = '0;
      last_m[d] = PORT_IO;
      exp_rd[d][0] = '0;
      exp_rd[d][1] = '0;
      for (int a = 0; a < 256; a++) begin
        ref_mem[d][a] = '0;
        ref_wr[d][a]  = 1'b0;
      end
    end
    repeat (3) @(posedge clk);
    #1;
    reset[0] = 1'b0;
    reset[1] = 1'b0;
    check_outputs_zero(0, "reset0");
    check_outputs_zero(1, "reset1");

    // cpu write 0x10 <- 0xA5
    do_txn(0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 8'hA5, 8'h00, 1'b0);
    // io read 0x20, RD_LAT=1, RAM returns 0x3C
    do_txn(0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h20, 8'h00, 8'h00, 1'b0);
    check("io_rdata_3c", io_rdata[0], 8'h3C);
    @(posedge clk); #1;
    check("io_rdata_3c_held", io_rdata[0], 8'h3C);
    // RD_LAT=3 read with req dropped after one cycle
    do_txn(1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h22, 32'h0, 8'h00, 8'h00, 1'b1);
    check("lat3_cpu_rdata", cpu_rdata[1], 8'h3E);

    // Both requesters held high from reset, all writes
    reset[0] = 1'b1;
    cpu_req[0] = 1'b1; cpu_we[0] = 1'b1; cpu_addr[0] = 32'h30; cpu_wdata[0] = 8'hC1;
    io_req[0]  = 1'b1; io_we[0]  = 1'b1; io_addr[0]  = 32'h31; io_wdata[0]  = 8'h1B;
    last_m[0] = PORT_IO;
    exp_rd[0][0] = '0;
    exp_rd[0][1] = '0;
    repeat (2) @(posedge clk);
    #1;
    reset[0] = 1'b0;
    n = 0;
    for (int cyc = 0; cyc < 60 && n < 4; cyc++) begin
      @(posedge clk); #1;
      if (cpu_ack[0] || io_ack[0]) begin
        w = model_pick(1'b1, 1'b1, last_m[0]);
        check("fair_onehot", cpu_ack[0] && io_ack[0], 0);
        check("fair_grant_io", io_ack[0], w == PORT_IO);
        if (w == PORT_CPU) begin
          ref_mem[0][8'h30] = 8'hC1; ref_wr[0][8'h30] = 1'b1;
        end else begin
          ref_mem[0][8'h31] = 8'h1B; ref_wr[0][8'h31] = 1'b1;
        end
        last_m[0] = w;
        n++;
        if (n == 4) begin
          cpu_req[0] = 1'b0;
          io_req[0]  = 1'b0;
        end
      end
    end
    check("fair_count", n, 4);
    cpu_req[0] = 1'b0;
    io_req[0]  = 1'b0;
    @(posedge clk); #1;

    // Randomized traffic on both instances
    for (int i = 0; i < 60; i++) begin
      int          d;
      logic        c_on, i_on;
      d    = i % 2;
      c_on = 1'($urandom_range(0, 1));
      i_on = c_on ? 1'($urandom_range(0, 1)) : 1'b1;
      do_txn(d, c_on, i_on,
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             32'($urandom_range(8'h40, 8'h47)), 32'($urandom_range(8'h40, 8'h47)),
             8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
    end

    // Reset pulsed during the WAIT cycle of a read
    io_req[0] = 1'b1; io_we[0] = 1'b0; io_addr[0] = 32'h44;
    @(posedge clk); #1;
    check("abort_access_re", mem_re[0], 1);
    @(posedge clk); #1;
    reset[0]  = 1'b1;
    io_req[0] = 1'b0;
    @(posedge clk); #1;
    reset[0] = 1'b0;
    check_outputs_zero(0, "abort");
    last_m[0] = PORT_IO;
    exp_rd[0][0] = '0;
    exp_rd[0][1] = '0;
    repeat (4) begin
      @(posedge clk); #1;
      check("abort_no_cpu_ack", cpu_ack[0], 0);
      check("abort_no_io_ack", io_ack[0], 0);
      check("abort_no_re", mem_re[0], 0);
      check("abort_no_we", mem_we[0], 0);
    end
    // First tie after reset goes to cpu
    do_txn(0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h50, 32'h51, 8'h77, 8'h88, 1'b0);
    do_txn(0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h50, 32'h51, 8'h00, 8'h00, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
